// File: rtl/ams_xadc_capture.sv
// ams_xadc_capture: reads each XADC conversion over DRP and keeps a per-channel
// table (boxcar average, min/max hold, hysteresis alarm) behind a register bus
// with a registered single-cycle ack.
// Optional build macro AMS_CAPTURE_TIMESTAMP_EN: per-channel completion
// timestamps from a free-running cycle counter, readable at 0x700 + 4*ch.

module ams_xadc_chan #(
  parameter int DW       = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
`ifdef AMS_CAPTURE_TIMESTAMP_EN
  input  logic [31:0]   i_tsc,
  output logic [31:0]   o_ts,
`endif
  input  logic          i_upd,
  input  logic [DW-1:0] i_sample,
  input  logic          i_clr_mm,
  input  logic          i_clr_avg,
  input  logic          i_wr_upper,
  input  logic          i_wr_lower,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_last,
  output logic [DW-1:0] o_min,
  output logic [DW-1:0] o_max,
  output logic [DW-1:0] o_upper,
  output logic [DW-1:0] o_lower,
  output logic          o_alarm
);
  localparam int AW = DW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] NSAMP = CW'(1 << AVG_LOG2);

  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_last, r_min, r_max, r_upper, r_lower;
  logic          r_alarm;

  logic [AW-1:0] w_sum;
  logic [CW-1:0] w_cnt;
  logic [DW-1:0] w_avg;
  logic          w_done;

  assign w_sum  = r_acc + AW'(i_sample);
  assign w_cnt  = r_cnt + CW'(1);
  assign w_avg  = w_sum[AW-1:AVG_LOG2];
  assign w_done = i_upd && (w_cnt == NSAMP);

  // Accumulate; on the final sample publish the average and update min/max/alarm.
  // Clears are applied last so they win over a same-cycle completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_min   <= '1;
      r_max   <= '0;
      r_upper <= '1;
      r_lower <= '0;
      r_alarm <= 1'b0;
    end else begin
      if (i_upd) begin
        if (w_done) begin
          r_last <= w_avg;
          r_acc  <= '0;
          r_cnt  <= '0;
          if (w_avg < r_min) r_min <= w_avg;
          if (w_avg > r_max) r_max <= w_avg;
          // thresholds read here are the pre-write values
          if (w_avg > r_upper)      r_alarm <= 1'b1;
          else if (w_avg < r_lower) r_alarm <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt;
        end
      end
      if (i_clr_avg) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (i_clr_mm) begin
        r_min <= '1;
        r_max <= '0;
      end
      if (i_wr_upper) r_upper <= i_wdata;
      if (i_wr_lower) r_lower <= i_wdata;
    end
  end

`ifdef AMS_CAPTURE_TIMESTAMP_EN
  logic [31:0] r_ts;
  // Stamp the cycle counter when a result completes.
  always_ff @(posedge clk_i) begin
    if (rst_i)       r_ts <= '0;
    else if (w_done) r_ts <= i_tsc;
  end
  assign o_ts = r_ts;
`endif

  assign o_last  = r_last;
  assign o_min   = r_min;
  assign o_max   = r_max;
  assign o_upper = r_upper;
  assign o_lower = r_lower;
  assign o_alarm = r_alarm;
endmodule

module ams_xadc_capture #(
  parameter int NCH      = 32,
  parameter int DW       = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TMO      = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           eoc_i,
  input  logic [4:0]     channel_i,
  output logic           drp_den_o,
  output logic [6:0]     drp_daddr_o,
  input  logic [15:0]    drp_do_i,
  input  logic           drp_drdy_i,
  input  logic [19:0]    addr_i,
  input  logic [31:0]    wdata_i,
  input  logic           wen_i,
  input  logic           ren_i,
  output logic [31:0]    rdata_o,
  output logic           ack_o,
  output logic           err_o,
  output logic [NCH-1:0] alarm_o,
  output logic           busy_o
);
  localparam int TW  = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [5:0]  NCH6 = 6'(NCH);
  localparam logic [31:0] ID   = {8'h00, 8'(NCH), 8'(DW), 8'(AVG_LOG2)};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_UPDATE = 2'd2} state_t;

  state_t          r_state, w_next;
  logic            w_start, w_tmo;
  logic            r_den;
  logic [4:0]      r_ch;
  logic [DW-1:0]   r_sample;
  logic [TW-1:0]   r_tcnt;
  logic [15:0]     r_tmo_cnt, r_drop_cnt;
  logic            r_ack, r_err;
  logic [31:0]     r_rdata;

  logic [NCH-1:0][DW-1:0] w_last, w_min, w_max, w_upper, w_lower;
  logic [NCH-1:0]         w_alarm;
`ifdef AMS_CAPTURE_TIMESTAMP_EN
  logic [31:0]            r_tsc;
  logic [NCH-1:0][31:0]   w_ts;
`endif

  logic            w_ch_ok, w_cok, w_mapped, w_wr_ok;
  logic [CIW-1:0]  w_ci;
  logic [31:0]     w_rval;
  logic            w_wr_up, w_wr_lo, w_ctrl;
  logic            w_clr_mm, w_clr_avg, w_drop;
  logic            w_unused_ok;

  assign w_ch_ok   = {1'b0, channel_i} < NCH6;
  assign w_cok     = addr_i[7:2] < NCH6;
  assign w_ci      = addr_i[CIW+1:2];
  assign w_drop    = eoc_i && (r_state != S_IDLE);
  assign w_clr_mm  = w_ctrl && wdata_i[0];
  assign w_clr_avg = w_ctrl && wdata_i[1];
  assign w_unused_ok = &{1'b0, wdata_i[31:DW], drp_do_i[15-DW:0]};

  // FSM state register; reset aborts any DRP transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: start on in-range EOC, wait for DRDY or give up after TMO cycles.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: if (eoc_i && w_ch_ok) begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: if (drp_drdy_i) begin
        w_next = S_UPDATE;
      end else if (r_tcnt == TW'(TMO - 1)) begin
        w_tmo  = 1'b1;
        w_next = S_IDLE;
      end
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // DRP side: enable pulse, latched channel, captured sample, wait timer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_den    <= 1'b0;
      r_ch     <= '0;
      r_sample <= '0;
      r_tcnt   <= '0;
    end else begin
      r_den <= w_start;
      if (w_start) r_ch <= channel_i;
      if (r_state == S_WAIT && drp_drdy_i) r_sample <= drp_do_i[15:16-DW];
      r_tcnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_tcnt + TW'(1) : '0;
    end
  end

  // Saturating timeout / drop counters, cleared by control bit1.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_clr_avg) begin
      r_tmo_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_tmo && r_tmo_cnt != 16'hFFFF)   r_tmo_cnt  <= r_tmo_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

`ifdef AMS_CAPTURE_TIMESTAMP_EN
  // Free-running wrap-around cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_tsc <= '0;
    else       r_tsc <= r_tsc + 32'd1;
  end
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ams_xadc_chan #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
`ifdef AMS_CAPTURE_TIMESTAMP_EN
      .i_tsc      (r_tsc),
      .o_ts       (w_ts[g]),
`endif
      .i_upd      (r_state == S_UPDATE && r_ch == 5'(g)),
      .i_sample   (r_sample),
      .i_clr_mm   (w_clr_mm),
      .i_clr_avg  (w_clr_avg),
      .i_wr_upper (w_wr_up && w_ci == CIW'(g)),
      .i_wr_lower (w_wr_lo && w_ci == CIW'(g)),
      .i_wdata    (wdata_i[DW-1:0]),
      .o_last     (w_last[g]),
      .o_min      (w_min[g]),
      .o_max      (w_max[g]),
      .o_upper    (w_upper[g]),
      .o_lower    (w_lower[g]),
      .o_alarm    (w_alarm[g])
    );
  end

  // Address decode and read mux; anything above 0x7FF or misaligned is unmapped.
  always_comb begin
    w_mapped = 1'b0;
    w_rval   = '0;
    if (addr_i[19:11] == '0 && addr_i[1:0] == 2'b00) begin
      case (addr_i[10:8])
        3'd0: begin w_mapped = w_cok; w_rval = 32'(w_last[w_ci]);  end
        3'd1: begin w_mapped = w_cok; w_rval = 32'(w_min[w_ci]);   end
        3'd2: begin w_mapped = w_cok; w_rval = 32'(w_max[w_ci]);   end
        3'd3: begin w_mapped = w_cok; w_rval = 32'(w_upper[w_ci]); end
        3'd4: begin w_mapped = w_cok; w_rval = 32'(w_lower[w_ci]); end
        3'd6: case (addr_i[7:0])
          8'h00: w_mapped = 1'b1;
          8'h04: begin w_mapped = 1'b1; w_rval = 32'(w_alarm); end
          8'h08: begin w_mapped = 1'b1; w_rval = {r_drop_cnt, r_tmo_cnt}; end
          8'h0C: begin w_mapped = 1'b1; w_rval = ID; end
          default: ;
        endcase
`ifdef AMS_CAPTURE_TIMESTAMP_EN
        3'd7: begin w_mapped = w_cok; w_rval = w_ts[w_ci]; end
`endif
        default: ;
      endcase
    end
  end

  assign w_wr_ok = wen_i && w_mapped;
  assign w_wr_up = w_wr_ok && addr_i[10:8] == 3'd3;
  assign w_wr_lo = w_wr_ok && addr_i[10:8] == 3'd4;
  assign w_ctrl  = w_wr_ok && addr_i[10:8] == 3'd6 && addr_i[7:0] == 8'h00;

  // Bus response: ack one cycle after any strobe, data only on mapped reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= wen_i || ren_i;
      r_err   <= (wen_i || ren_i) && !w_mapped;
      r_rdata <= (ren_i && !wen_i && w_mapped) ? w_rval : '0;
    end
  end

  assign drp_den_o   = r_den;
  assign drp_daddr_o = {2'b00, r_ch};
  assign rdata_o     = r_rdata;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign alarm_o     = w_alarm;
  assign busy_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_ams_xadc_capture.sv
// Directed bench for ams_xadc_capture (default parameters, no timestamp build).
module tb_ams_xadc_capture;
  logic        clk = 1'b0, rst = 1'b1;
  logic        eoc = 1'b0, drdy = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [4:0]  channel = '0;
  logic [15:0] drp_do = '0;
  logic [19:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        den, ack, err, busy;
  logic [6:0]  daddr;
  logic [31:0] rdata;
  logic [31:0] alarm;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  ams_xadc_capture dut (
    .clk_i(clk), .rst_i(rst), .eoc_i(eoc), .channel_i(channel),
    .drp_den_o(den), .drp_daddr_o(daddr), .drp_do_i(drp_do), .drp_drdy_i(drdy),
    .addr_i(addr), .wdata_i(wdata), .wen_i(wen), .ren_i(ren),
    .rdata_o(rdata), .ack_o(ack), .err_o(err), .alarm_o(alarm), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one bus access; expected response queued at drive time, popped on ack
  task automatic bus(input bit wr, input logic [19:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input logic ee, input string tag);
    logic [32:0] e;
    exp_q.push_back({ee, ed});
    addr = a; wdata = wd; wen = wr; ren = !wr;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
    chk({tag, " ack"}, 32'(ack), 32'd1);
    e = exp_q.pop_front();
    chk({tag, " err"}, 32'(err), 32'(e[32]));
    if (!wr) chk({tag, " data"}, rdata, e[31:0]);
  endtask

  // one conversion with immediate DRDY; optional control write during UPDATE
  task automatic conv(input logic [4:0] ch, input logic [15:0] d, input logic [31:0] ctl);
    eoc = 1'b1; channel = ch;
    @(posedge clk); #1;
    eoc = 1'b0;
    chk("den", 32'(den), 32'd1);
    chk("daddr", 32'(daddr), 32'(ch));
    drdy = 1'b1; drp_do = d;
    @(posedge clk); #1;
    drdy = 1'b0;
    if (ctl != 0) begin wen = 1'b1; addr = 20'h600; wdata = ctl; end
    @(posedge clk); #1;
    wen = 1'b0;
    chk("idle after update", 32'(busy), 32'd0);
    if (ctl != 0) chk("ctrl ack", 32'(ack), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // reset state
    chk("rst den", 32'(den), 32'd0);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst alarm", alarm, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    bus(0, 20'h104, 0, 32'h00000FFF, 0, "rst min1");
    bus(0, 20'h300, 0, 32'h00000FFF, 0, "rst upper0");
    bus(0, 20'h400, 0, 32'h00000000, 0, "rst lower0");
    bus(0, 20'h60C, 0, 32'h00200C02, 0, "id");

    // averaging on ch3
    conv(5'd3, 16'h1000, 0);
    conv(5'd3, 16'h2000, 0);
    conv(5'd3, 16'h3000, 0);
    bus(0, 20'h00C, 0, 32'h0, 0, "avg partial");
    conv(5'd3, 16'h4000, 0);
    bus(0, 20'h00C, 0, 32'h280, 0, "avg last");
    bus(0, 20'h10C, 0, 32'h280, 0, "avg min");
    bus(0, 20'h20C, 0, 32'h280, 0, "avg max");

    // hysteresis alarm on ch0
    bus(1, 20'h300, 32'h800, 0, 0, "wr upper");
    bus(1, 20'h400, 32'h700, 0, 0, "wr lower");
    repeat (4) conv(5'd0, 16'h8100, 0);
    chk("alarm set", 32'(alarm[0]), 32'd1);
    bus(0, 20'h604, 0, 32'h1, 0, "alarm vec");
    repeat (4) conv(5'd0, 16'h7500, 0);
    chk("alarm hold", 32'(alarm[0]), 32'd1);
    repeat (4) conv(5'd0, 16'h6F00, 0);
    chk("alarm clear", 32'(alarm[0]), 32'd0);
    bus(0, 20'h000, 0, 32'h6F0, 0, "ch0 last");

    // DRP timeout
    eoc = 1'b1; channel = 5'd5;
    @(posedge clk); #1;
    eoc = 1'b0;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    chk("timeout cycles", 32'(n), 32'd15);
    bus(0, 20'h608, 0, 32'h00000001, 0, "tmo cnt");

    // dropped EOC while busy, first channel still completes
    eoc = 1'b1; channel = 5'd7;
    @(posedge clk); #1;
    eoc = 1'b0;
    @(posedge clk); #1;
    eoc = 1'b1; channel = 5'd8;
    @(posedge clk); #1;
    eoc = 1'b0; drdy = 1'b1; drp_do = 16'h1230;
    @(posedge clk); #1;
    drdy = 1'b0;
    @(posedge clk); #1;
    chk("drop idle", 32'(busy), 32'd0);
    conv(5'd7, 16'h1230, 0);
    conv(5'd7, 16'h1230, 0);
    conv(5'd7, 16'h1270, 0);
    bus(0, 20'h01C, 0, 32'h124, 0, "ch7 last");
    bus(0, 20'h020, 0, 32'h0, 0, "ch8 untouched");
    bus(0, 20'h608, 0, 32'h00010001, 0, "drop cnt");

    // unmapped / read-only accesses
    bus(0, 20'h7FC, 0, 32'h0, 1, "unmapped 7FC");
    bus(0, 20'h500, 0, 32'h0, 1, "unmapped 500");
    bus(1, 20'h000, 32'hABC, 0, 0, "wr ro");
    bus(0, 20'h000, 0, 32'h6F0, 0, "ro unchanged");

    // clear min/max coinciding with completing UPDATE
    repeat (3) conv(5'd3, 16'h5000, 0);
    conv(5'd3, 16'h5000, 32'h1);
    bus(0, 20'h00C, 0, 32'h500, 0, "clr last");
    bus(0, 20'h10C, 0, 32'hFFF, 0, "clr min");
    bus(0, 20'h20C, 0, 32'h000, 0, "clr max");
    bus(1, 20'h600, 32'h2, 0, 0, "clr counters");
    bus(0, 20'h608, 0, 32'h0, 0, "counters zero");
    bus(0, 20'h600, 0, 32'h0, 0, "ctrl reads 0");

    // reset during WAIT, late DRDY ignored
    eoc = 1'b1; channel = 5'd1;
    @(posedge clk); #1;
    eoc = 1'b0;
    chk("wait busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw busy", 32'(busy), 32'd0);
    chk("rstw den", 32'(den), 32'd0);
    chk("rstw alarm", alarm, 32'd0);
    chk("rstw ack", 32'(ack), 32'd0);
    drdy = 1'b1; drp_do = 16'hFFF0;
    @(posedge clk); #1;
    drdy = 1'b0;
    @(posedge clk); #1;
    chk("late drdy busy", 32'(busy), 32'd0);
    bus(0, 20'h004, 0, 32'h0, 0, "late drdy last");
    bus(0, 20'h10C, 0, 32'hFFF, 0, "post rst min");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
